// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: producer, register-bank and bypass-lookup signals of the write-back queue
interface wb_write_queue_if #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int NREG = 16
);
    logic                 alu_valid;
    logic [AW-1:0]        alu_dr;
    logic signed [DW-1:0] alu_data;
    logic                 alu_ready;
    logic                 mem_valid;
    logic [AW-1:0]        mem_dr;
    logic signed [DW-1:0] mem_data;
    logic                 mem_ready;
    logic                 rf_write;
    logic [AW-1:0]        rf_dr;
    logic signed [DW-1:0] rf_wrData;
    logic [NREG-1:0]      busy_mask;
    logic                 full;
    logic                 empty;
    logic                 err_drop;
    logic [AW-1:0]        chk_sr;
    logic                 chk_hit;
    logic signed [DW-1:0] chk_data;

    modport slave (
        input  alu_valid, alu_dr, alu_data, mem_valid, mem_dr, mem_data, chk_sr,
        output alu_ready, mem_ready, rf_write, rf_dr, rf_wrData, busy_mask, full, empty, err_drop,
               chk_hit, chk_data
    );

    modport master (
        output alu_valid, alu_dr, alu_data, mem_valid, mem_dr, mem_data, chk_sr,
        input  alu_ready, mem_ready, rf_write, rf_dr, rf_wrData, busy_mask, full, empty, err_drop,
               chk_hit, chk_data
    );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back FIFO from ALU/load unit to the register bank write port.
// Optional macro WB_BYPASS_EN builds the chk_sr forwarding lookup; without it chk_hit/chk_data are 0.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int NREG  = 16
) (
    input logic             clk,
    input logic             reset,
    wb_write_queue_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]        dr_q [DEPTH];
    logic [AW-1:0]        dr_d [DEPTH];
    logic signed [DW-1:0] data_q [DEPTH];
    logic signed [DW-1:0] data_d [DEPTH];
    logic [PW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d, wp;
    logic [CW-1:0]        count_q, count_d;
    logic                 wr_q, wr_d;
    logic [AW-1:0]        wr_dr_q, wr_dr_d;
    logic signed [DW-1:0] wr_data_q, wr_data_d;
    logic                 err_q, err_d;
    logic                 mem_ready, alu_ready, pop;
    logic                 mem_acc, alu_acc, mem_bad, alu_bad, mem_keep, alu_keep;
    logic [NREG-1:0]      busy;

    // Accept/filter producers (mem slot first), pop the head into the output stage, update count
    always_comb begin
        mem_ready = count_q < CW'(DEPTH);
        alu_ready = (count_q <= CW'(DEPTH - 2)) || (count_q == CW'(DEPTH - 1) && !wb.mem_valid);
        mem_acc   = wb.mem_valid && mem_ready;
        alu_acc   = wb.alu_valid && alu_ready;
        mem_bad   = mem_acc && ({1'b0, wb.mem_dr} >= (AW + 1)'(NREG));
        alu_bad   = alu_acc && ({1'b0, wb.alu_dr} >= (AW + 1)'(NREG));
        mem_keep  = mem_acc && !mem_bad && wb.mem_dr != '0;
        alu_keep  = alu_acc && !alu_bad && wb.alu_dr != '0;
        pop       = count_q != '0;
        dr_d      = dr_q;
        data_d    = data_q;
        wp        = wptr_q;
        if (mem_keep) begin
            dr_d[wp]   = wb.mem_dr;
            data_d[wp] = wb.mem_data;
            wp         = wp + PW'(1);
        end
        if (alu_keep) begin
            dr_d[wp]   = wb.alu_dr;
            data_d[wp] = wb.alu_data;
            wp         = wp + PW'(1);
        end
        wptr_d    = wp;
        rptr_d    = rptr_q + PW'(pop);
        count_d   = count_q + CW'(mem_keep) + CW'(alu_keep) - CW'(pop);
        wr_d      = pop;
        wr_dr_d   = pop ? dr_q[rptr_q] : wr_dr_q;
        wr_data_d = pop ? data_q[rptr_q] : wr_data_q;
        err_d     = mem_bad || alu_bad;
    end

    // Pending destinations: live FIFO slots plus the output stage while it is writing
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(i) - rptr_q} < count_q) busy = busy | (NREG'(1) << dr_q[i]);
        if (wr_q) busy = busy | (NREG'(1) << wr_dr_q);
    end

    // State registers; reset drops every pending entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dr_q      <= '{default: '0};
            data_q    <= '{default: '0};
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            wr_q      <= 1'b0;
            wr_dr_q   <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            dr_q      <= dr_d;
            data_q    <= data_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            wr_q      <= wr_d;
            wr_dr_q   <= wr_dr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign wb.mem_ready = mem_ready;
    assign wb.alu_ready = alu_ready;
    assign wb.rf_write  = wr_q;
    assign wb.rf_dr     = wr_dr_q;
    assign wb.rf_wrData = wr_data_q;
    assign wb.busy_mask = busy;
    assign wb.full      = count_q == CW'(DEPTH);
    assign wb.empty     = count_q == '0 && !wr_q;
    assign wb.err_drop  = err_q;

`ifdef WB_BYPASS_EN
    logic                 hit;
    logic signed [DW-1:0] hit_data;

    // Youngest match wins: scan output stage, then head to tail, later hits override earlier ones
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        if (wb.chk_sr != '0) begin
            if (wr_q && wr_dr_q == wb.chk_sr) begin
                hit      = 1'b1;
                hit_data = wr_data_q;
            end
            for (int k = 0; k < DEPTH; k++)
                if (CW'(k) < count_q && dr_q[rptr_q + PW'(k)] == wb.chk_sr) begin
                    hit      = 1'b1;
                    hit_data = data_q[rptr_q + PW'(k)];
                end
        end
    end

    assign wb.chk_hit  = hit;
    assign wb.chk_data = hit_data;
`else
    logic unused_chk;
    assign unused_chk  = ^wb.chk_sr;
    assign wb.chk_hit  = 1'b0;
    assign wb.chk_data = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed checks plus a scoreboarded stream for wb_write_queue
module tb_wb_write_queue;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_write_queue_if #(.AW(5), .DW(32), .NREG(16)) wb ();

    wb_write_queue #(.DEPTH(4), .AW(5), .DW(32), .NREG(16)) dut (
        .clk  (clk),
        .reset(reset),
        .wb   (wb.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] dr, input logic [31:0] d);
        wb.alu_valid = 1'b1;
        wb.alu_dr    = dr;
        wb.alu_data  = d;
    endtask

    task automatic mem(input logic [4:0] dr, input logic [31:0] d);
        wb.mem_valid = 1'b1;
        wb.mem_dr    = dr;
        wb.mem_data  = d;
    endtask

    logic [36:0] q[$];
    logic [36:0] e;
    int          sent, written;
    bit          mv, av, mr, ar, pop;

    initial begin
        idle();
        wb.alu_dr = '0; wb.alu_data = '0; wb.mem_dr = '0; wb.mem_data = '0; wb.chk_sr = '0;
        tick();
        tick();
        check("rst_rf_write", wb.rf_write, 0);
        check("rst_rf_dr", wb.rf_dr, 0);
        check("rst_rf_data", $unsigned(wb.rf_wrData), 0);
        check("rst_busy", wb.busy_mask, 0);
        check("rst_full", wb.full, 0);
        check("rst_empty", wb.empty, 1);
        check("rst_err", wb.err_drop, 0);
        check("rst_chk_hit", wb.chk_hit, 0);
        check("rst_chk_data", $unsigned(wb.chk_data), 0);
        check("rst_mem_ready", wb.mem_ready, 1);
        check("rst_alu_ready", wb.alu_ready, 1);
        #2 reset = 1'b1;
        tick();

        // single ALU result, latency 2 to the bank write
        alu(5'd3, 32'h0000_00AA);
        #1 check("t1_alu_ready", wb.alu_ready, 1);
        tick();
        idle();
        check("t1_busy_fifo", wb.busy_mask, 16'h0008);
        check("t1_wr_early", wb.rf_write, 0);
        check("t1_not_empty", wb.empty, 0);
        tick();
        check("t1_rf_write", wb.rf_write, 1);
        check("t1_rf_dr", wb.rf_dr, 3);
        check("t1_rf_data", $unsigned(wb.rf_wrData), 32'h0000_00AA);
        check("t1_busy_out", wb.busy_mask, 16'h0008);
        tick();
        check("t1_wr_done", wb.rf_write, 0);
        check("t1_busy_clr", wb.busy_mask, 0);
        check("t1_empty", wb.empty, 1);
        check("t1_dr_hold", wb.rf_dr, 3);

        // both producers on one edge: mem first
        mem(5'd5, 32'hFFFF_FFF9);
        alu(5'd6, 32'd42);
        tick();
        idle();
        check("t2_busy_both", wb.busy_mask, 16'h0060);
        tick();
        check("t2_wr1", wb.rf_write, 1);
        check("t2_dr1", wb.rf_dr, 5);
        check("t2_data1", $unsigned(wb.rf_wrData), 32'hFFFF_FFF9);
        check("t2_busy1", wb.busy_mask, 16'h0060);
        tick();
        check("t2_wr2", wb.rf_write, 1);
        check("t2_dr2", wb.rf_dr, 6);
        check("t2_data2", $unsigned(wb.rf_wrData), 32'd42);
        check("t2_busy2", wb.busy_mask, 16'h0040);
        tick();
        check("t2_wr_done", wb.rf_write, 0);
        check("t2_busy_clr", wb.busy_mask, 0);

        // filtered destinations: r0 silently dropped, out-of-range flagged once
        mem(5'd20, 32'd1);
        alu(5'd0, 32'd2);
        tick();
        idle();
        check("t4_err_pulse", wb.err_drop, 1);
        check("t4_no_write", wb.rf_write, 0);
        check("t4_empty", wb.empty, 1);
        check("t4_busy", wb.busy_mask, 0);
        tick();
        check("t4_err_end", wb.err_drop, 0);
        check("t4_no_write2", wb.rf_write, 0);
        mem(5'd20, 32'd3);
        alu(5'd31, 32'd4);
        tick();
        idle();
        check("t4_err_both", wb.err_drop, 1);
        tick();
        check("t4_err_both_end", wb.err_drop, 0);
        check("t4_no_write3", wb.rf_write, 0);

        // async reset with entries pending
        mem(5'd8, 32'd8);
        alu(5'd9, 32'd9);
        tick();
        idle();
        alu(5'd10, 32'd10);
        tick();
        idle();
        check("t5_busy_pend", wb.busy_mask, 16'h0700);
        #3 reset = 1'b0;
        #1;
        check("t5_rst_write", wb.rf_write, 0);
        check("t5_rst_busy", wb.busy_mask, 0);
        check("t5_rst_empty", wb.empty, 1);
        #2 reset = 1'b1;
        tick();
        check("t5_still_idle", wb.rf_write, 0);
        alu(5'd11, 32'h55);
        tick();
        idle();
        check("t5_busy_new", wb.busy_mask, 16'h0800);
        check("t5_wr_early", wb.rf_write, 0);
        tick();
        check("t5_wr", wb.rf_write, 1);
        check("t5_dr", wb.rf_dr, 11);
        check("t5_data", $unsigned(wb.rf_wrData), 32'h55);
        tick();
        check("t5_wr_done", wb.rf_write, 0);

        // bypass lookup with two pending writes to r7
        alu(5'd7, 32'd1);
        tick();
        alu(5'd7, 32'd2);
        tick();
        idle();
        wb.chk_sr = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("t6_hit", wb.chk_hit, 1);
        check("t6_data", $unsigned(wb.chk_data), 32'd2);
`else
        check("t6_hit", wb.chk_hit, 0);
        check("t6_data", $unsigned(wb.chk_data), 0);
`endif
        wb.chk_sr = '0;
        tick();
        tick();
        tick();
        check("t6_drained", wb.empty, 1);

        // scoreboarded stream of 64 results, producers mostly valid
        sent = 0;
        written = 0;
        for (int c = 0; c < 600 && (sent < 64 || q.size() > 0); c++) begin
            mv = sent < 64 && (c < 20 || $urandom_range(0, 3) != 0);
            av = (sent + int'(mv)) < 64 && (c < 20 || $urandom_range(0, 3) != 0);
            wb.mem_valid = mv;
            wb.mem_dr    = 5'($urandom_range(1, 15));
            wb.mem_data  = $urandom;
            wb.alu_valid = av;
            wb.alu_dr    = 5'($urandom_range(1, 15));
            wb.alu_data  = $urandom;
            #1;
            mr = q.size() < 4;
            ar = q.size() <= 2 || (q.size() == 3 && !mv);
            check("t3_mem_ready", wb.mem_ready, mr);
            check("t3_alu_ready", wb.alu_ready, ar);
            check("t3_full", wb.full, q.size() == 4);
            pop = q.size() > 0;
            if (pop) e = q.pop_front();
            if (mv && mr) begin
                q.push_back({wb.mem_dr, $unsigned(wb.mem_data)});
                sent++;
            end
            if (av && ar) begin
                q.push_back({wb.alu_dr, $unsigned(wb.alu_data)});
                sent++;
            end
            tick();
            check("t3_rf_write", wb.rf_write, pop);
            if (pop) begin
                check("t3_rf_dr", wb.rf_dr, e[36:32]);
                check("t3_rf_data", $unsigned(wb.rf_wrData), e[31:0]);
                written++;
            end
        end
        idle();
        tick();
        check("t3_written", written, 64);
        check("t3_end_empty", wb.empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
